// File: rtl/obstacle_scheduler_pkg.sv
// rtl/obstacle_scheduler_pkg.sv - shared constants, state encoding and LFSR step for the obstacle scheduler
package obstacle_scheduler_pkg;

  localparam int DEF_NUM_SLOTS    = 3;
  localparam int DEF_SPAWN_X      = 400;
  localparam int DEF_DESPAWN_X    = -32;
  localparam int DEF_MIN_GAP      = 40;
  localparam int DEF_GAP_MASK     = 63;
  localparam int DEF_SPEED_INIT   = 3;
  localparam int DEF_SPEED_MAX    = 8;
  localparam int DEF_LEVEL_FRAMES = 600;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Galois feedback mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } sched_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// rtl/obstacle_scheduler_lfsr16.sv - 16-bit Galois LFSR with enable, shared with cactus variant selection
module lfsr16
  import obstacle_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        game_clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  // One shift per enabled frame; seed must be nonzero or the register locks up
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - obstacle field controller: spawn, scroll, retire, speed ramp and score
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int          NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int          SPAWN_X      = DEF_SPAWN_X,
  parameter int          DESPAWN_X    = DEF_DESPAWN_X,
  parameter int          MIN_GAP      = DEF_MIN_GAP,
  parameter int          GAP_MASK     = DEF_GAP_MASK,
  parameter int          SPEED_INIT   = DEF_SPEED_INIT,
  parameter int          SPEED_MAX    = DEF_SPEED_MAX,
  parameter int          LEVEL_FRAMES = DEF_LEVEL_FRAMES,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic                      game_clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      restart,
  input  logic                      collided,
  output logic [12*NUM_SLOTS-1:0]   obs_x,
  output logic [NUM_SLOTS-1:0]      obs_valid,
  output logic [3:0]                speed,
  output logic [3:0]                level,
  output logic [15:0]               score,
  output logic                      spawn_pulse
);

  localparam logic [11:0]        SPAWN_X12   = 12'(SPAWN_X);
  localparam logic signed [11:0] DESPAWN_X12 = 12'(DESPAWN_X);
  localparam logic [15:0]        MIN_GAP16   = 16'(MIN_GAP);
  localparam logic [15:0]        GAP_MASK16  = 16'(GAP_MASK);
  localparam logic [3:0]         SPEED_INIT4 = 4'(SPEED_INIT);
  localparam logic [3:0]         SPEED_MAX4  = 4'(SPEED_MAX);
  localparam logic [15:0]        LEVEL_LAST  = 16'(LEVEL_FRAMES - 1);

  sched_state_t                 state;
  logic [15:0]                  gap_timer;
  logic [15:0]                  frame_cnt;
  logic [15:0]                  lfsr_value;
  logic                         advance;
  logic [11:0]                  nx;
  logic [12*NUM_SLOTS-1:0]      moved_x;
  logic [NUM_SLOTS-1:0]         moved_valid;
  logic [12*NUM_SLOTS-1:0]      spawned_x;
  logic [NUM_SLOTS-1:0]         spawned_valid;
  logic [NUM_SLOTS-1:0]         free_onehot;
  logic [2:0]                   retire_cnt;
  logic [16:0]                  score_sum;
  logic                         spawn_now;

  assign advance   = (state == ST_RUN) && run && !collided && !restart;
  assign score_sum = {1'b0, score} + 17'(retire_cnt);
  assign spawn_now = (gap_timer == 16'd0) && (|free_onehot);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .game_clk (game_clk),
    .rst      (rst),
    .en       (advance),
    .value    (lfsr_value)
  );

  // Scroll every occupied slot, retire those past the left edge, pick the lowest slot free before this frame
  always_comb begin
    moved_x     = obs_x;
    moved_valid = obs_valid;
    retire_cnt  = 3'd0;
    nx          = 12'd0;
    free_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (obs_valid[i]) begin
        nx = obs_x[12*i +: 12] - {8'd0, speed};
        moved_x[12*i +: 12] = nx;
        if ($signed(nx) <= DESPAWN_X12) begin
          moved_valid[i] = 1'b0;
          retire_cnt     = retire_cnt + 3'd1;
        end
      end
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!obs_valid[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  // Drop a fresh obstacle into the chosen slot; it is not scrolled on its spawn frame
  always_comb begin
    spawned_x     = moved_x;
    spawned_valid = moved_valid;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free_onehot[i]) begin
        spawned_x[12*i +: 12] = SPAWN_X12;
        spawned_valid[i]      = 1'b1;
      end
    end
  end

  // Game-state machine and all per-frame field updates
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      obs_x       <= '0;
      obs_valid   <= '0;
      speed       <= SPEED_INIT4;
      level       <= 4'd0;
      score       <= 16'd0;
      spawn_pulse <= 1'b0;
      gap_timer   <= MIN_GAP16;
      frame_cnt   <= 16'd0;
    end else if (restart) begin
      // score stays visible until the next game starts
      state       <= ST_IDLE;
      obs_x       <= '0;
      obs_valid   <= '0;
      spawn_pulse <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          spawn_pulse <= 1'b0;
          if (run) begin
            state     <= ST_RUN;
            obs_x     <= '0;
            obs_valid <= '0;
            gap_timer <= MIN_GAP16;
            frame_cnt <= 16'd0;
            speed     <= SPEED_INIT4;
            level     <= 4'd0;
            score     <= 16'd0;
          end
        end
        ST_RUN: begin
          spawn_pulse <= 1'b0;
          if (collided) begin
            state <= ST_FROZEN;
          end else if (run) begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (gap_timer != 16'd0) begin
              gap_timer <= gap_timer - 16'd1;
              obs_x     <= moved_x;
              obs_valid <= moved_valid;
            end else if (spawn_now) begin
              gap_timer   <= MIN_GAP16 + (lfsr_value & GAP_MASK16);
              spawn_pulse <= 1'b1;
              obs_x       <= spawned_x;
              obs_valid   <= spawned_valid;
            end else begin
              obs_x     <= moved_x;
              obs_valid <= moved_valid;
            end
            if (frame_cnt == LEVEL_LAST) begin
              frame_cnt <= 16'd0;
              if (speed < SPEED_MAX4) begin
                speed <= speed + 4'd1;
                level <= level + 4'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        ST_FROZEN: begin
          spawn_pulse <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - scoreboard bench for obstacle_scheduler (default and tight-gap instances)
module tb_obstacle_scheduler;

  logic game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  logic rst = 1'b0;
  logic run = 1'b0;
  logic restart = 1'b0;
  logic collided = 1'b0;

  logic [35:0] obs_x0, obs_x1;
  logic [2:0]  v0, v1;
  logic [3:0]  sp0, sp1, lv0, lv1;
  logic [15:0] sc0, sc1;
  logic        pu0, pu1;

  obstacle_scheduler u_dut0 (
    .game_clk(game_clk), .rst(rst), .run(run), .restart(restart), .collided(collided),
    .obs_x(obs_x0), .obs_valid(v0), .speed(sp0), .level(lv0), .score(sc0), .spawn_pulse(pu0)
  );

  obstacle_scheduler #(.MIN_GAP(1), .GAP_MASK(0)) u_dut1 (
    .game_clk(game_clk), .rst(rst), .run(run), .restart(restart), .collided(collided),
    .obs_x(obs_x1), .obs_valid(v1), .speed(sp1), .level(lv1), .score(sc1), .spawn_pulse(pu1)
  );

  typedef struct packed {
    logic [35:0] x;
    logic [2:0]  v;
    logic [3:0]  sp;
    logic [3:0]  lv;
    logic [15:0] sc;
    logic        pu;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  obs_t last0, last1;

  int checks = 0;
  int errors = 0;

  // reference model, one entry per instance
  int          m_st[2];
  int          m_x[2][3];
  bit          m_v[2][3];
  int          m_sp[2], m_lv[2], m_sc[2], m_pu[2], m_gap[2], m_fc[2];
  logic [15:0] m_lfsr[2];
  int          m_mg[2] = '{40, 1};
  int          m_gm[2] = '{63, 0};

  function automatic void m_reset(int k);
    m_st[k] = 0;
    for (int i = 0; i < 3; i++) begin
      m_x[k][i] = 0;
      m_v[k][i] = 1'b0;
    end
    m_sp[k] = 3; m_lv[k] = 0; m_sc[k] = 0; m_pu[k] = 0;
    m_gap[k] = m_mg[k]; m_fc[k] = 0; m_lfsr[k] = 16'hACE1;
  endfunction

  function automatic obs_t m_pack(int k);
    obs_t r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r.x[12*i +: 12] = 12'(m_x[k][i]);
      r.v[i] = m_v[k][i];
    end
    r.sp = 4'(m_sp[k]);
    r.lv = 4'(m_lv[k]);
    r.sc = 16'(m_sc[k]);
    r.pu = m_pu[k][0];
    return r;
  endfunction

  function automatic void m_step(int k, bit r, bit rs, bit c);
    int nx[3];
    bit nv[3];
    int ret;
    int freei;
    if (rs) begin
      m_st[k] = 0;
      for (int i = 0; i < 3; i++) begin
        m_x[k][i] = 0;
        m_v[k][i] = 1'b0;
      end
      m_pu[k] = 0;
      return;
    end
    if (m_st[k] == 0) begin
      m_pu[k] = 0;
      if (r) begin
        m_st[k] = 1;
        for (int i = 0; i < 3; i++) begin
          m_x[k][i] = 0;
          m_v[k][i] = 1'b0;
        end
        m_gap[k] = m_mg[k]; m_fc[k] = 0; m_sp[k] = 3; m_lv[k] = 0; m_sc[k] = 0;
      end
    end else if (m_st[k] == 1) begin
      m_pu[k] = 0;
      if (c) begin
        m_st[k] = 2;
      end else if (r) begin
        ret = 0;
        freei = -1;
        for (int i = 0; i < 3; i++) begin
          nx[i] = m_x[k][i];
          nv[i] = m_v[k][i];
          if (m_v[k][i]) begin
            nx[i] = m_x[k][i] - m_sp[k];
            if (nx[i] <= -32) begin
              nv[i] = 1'b0;
              ret++;
            end
          end
        end
        for (int i = 2; i >= 0; i--) if (!m_v[k][i]) freei = i;
        if (m_gap[k] != 0) begin
          m_gap[k]--;
        end else if (freei >= 0) begin
          nx[freei] = 400;
          nv[freei] = 1'b1;
          m_pu[k] = 1;
          m_gap[k] = m_mg[k] + int'(m_lfsr[k] & 16'(m_gm[k]));
        end
        for (int i = 0; i < 3; i++) begin
          m_x[k][i] = nx[i];
          m_v[k][i] = nv[i];
        end
        m_sc[k] = (m_sc[k] + ret > 65535) ? 65535 : m_sc[k] + ret;
        m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 16'hB400) : (m_lfsr[k] >> 1);
        if (m_fc[k] == 599) begin
          m_fc[k] = 0;
          if (m_sp[k] < 8) begin
            m_sp[k]++;
            m_lv[k]++;
          end
        end else begin
          m_fc[k]++;
        end
      end
    end
  endfunction

  // one frame: predict, push, clock, pop and compare both instances
  task automatic frame(bit r, bit rs, bit c);
    obs_t e0, e1, a0, a1;
    run = r; restart = rs; collided = c;
    m_step(0, r, rs, c); q0.push_back(m_pack(0));
    m_step(1, r, rs, c); q1.push_back(m_pack(1));
    @(posedge game_clk); #1;
    e0 = q0.pop_front(); e1 = q1.pop_front();
    a0 = {obs_x0, v0, sp0, lv0, sc0, pu0};
    a1 = {obs_x1, v1, sp1, lv1, sc1, pu1};
    last0 = e0; last1 = e1;
    checks++;
    if (a0 !== e0) begin
      errors++;
      $display("FAIL frame_dut0 t=%0t got %h want %h", $time, a0, e0);
    end
    checks++;
    if (a1 !== e1) begin
      errors++;
      $display("FAIL frame_dut1 t=%0t got %h want %h", $time, a1, e1);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    m_reset(0); m_reset(1);
    checks++;
    if ({obs_x0, v0, sp0, lv0, sc0, pu0} !== {36'd0, 3'd0, 4'd3, 4'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut0 got x=%h v=%b sp=%0d lv=%0d sc=%0d pu=%b want zeros speed 3",
               obs_x0, v0, sp0, lv0, sc0, pu0);
    end
    checks++;
    if ({v1, sp1, sc1, pu1} !== {3'd0, 4'd3, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut1 got v=%b sp=%0d sc=%0d pu=%b want 0 3 0 0", v1, sp1, sc1, pu1);
    end
    @(posedge game_clk); #1;
    rst = 1'b0;
    frame(0, 0, 0);
  endtask

  task automatic test_first_spawn();
    frame(1, 0, 0);
    for (int n = 1; n <= 42; n++) begin
      frame(1, 0, 0);
      if (n == 40) begin
        checks++;
        if (pu0 !== 1'b0) begin errors++; $display("FAIL early_spawn got %b want 0", pu0); end
      end
      if (n == 41) begin
        checks++;
        if ({pu0, v0[0], obs_x0[11:0]} !== {1'b1, 1'b1, 12'd400}) begin
          errors++;
          $display("FAIL first_spawn got pu=%b v=%b x=%0d want 1 1 400", pu0, v0[0], obs_x0[11:0]);
        end
      end
      if (n == 42) begin
        checks++;
        if (obs_x0[11:0] !== 12'd397) begin
          errors++; $display("FAIL first_move got %0d want 397", obs_x0[11:0]);
        end
      end
      if (n == 2) begin
        checks++;
        if ({pu1, v1} !== {1'b1, 3'b001}) begin
          errors++; $display("FAIL tight_spawn0 got pu=%b v=%b want 1 001", pu1, v1);
        end
      end
      if (n == 6) begin
        checks++;
        if (v1 !== 3'b111) begin errors++; $display("FAIL tight_full got %b want 111", v1); end
      end
    end
  endtask

  task automatic test_retire_and_exhaustion();
    for (int n = 43; n <= 185; n++) begin
      frame(1, 0, 0);
      if (n == 146) begin
        checks++;
        if ({v1[0], pu1, sc1} !== {1'b0, 1'b0, 16'd1}) begin
          errors++; $display("FAIL tight_retire got v0=%b pu=%b sc=%0d want 0 0 1", v1[0], pu1, sc1);
        end
      end
      if (n == 147) begin
        checks++;
        if ({pu1, v1[0], obs_x1[11:0]} !== {1'b1, 1'b1, 12'd400}) begin
          errors++; $display("FAIL tight_reuse got pu=%b v0=%b x=%0d want 1 1 400", pu1, v1[0], obs_x1[11:0]);
        end
      end
      if (n == 184) begin
        checks++;
        if (v0[0] !== 1'b1) begin errors++; $display("FAIL retire_early got %b want 1", v0[0]); end
      end
      if (n == 185) begin
        checks++;
        if ({v0[0], sc0, obs_x0[11:0]} !== {1'b0, 16'd1, 12'hFE0}) begin
          errors++; $display("FAIL retire got v=%b sc=%0d x=%h want 0 1 fe0", v0[0], sc0, obs_x0[11:0]);
        end
      end
    end
  endtask

  task automatic test_pause();
    obs_t s0, s1;
    for (int n = 0; n < 10; n++) begin
      if (last0.pu == 1'b0 && last1.pu == 1'b0) break;
      frame(1, 0, 0);
    end
    s0 = last0; s1 = last1;
    for (int n = 0; n < 10; n++) begin
      frame(0, 0, 0);
      checks++;
      if ({obs_x0, v0, sp0, lv0, sc0, pu0} !== s0 || {obs_x1, v1, sp1, lv1, sc1, pu1} !== s1) begin
        errors++;
        $display("FAIL pause got %h/%h want %h/%h", {obs_x0, v0, sp0, lv0, sc0, pu0},
                 {obs_x1, v1, sp1, lv1, sc1, pu1}, s0, s1);
      end
    end
  endtask

  task automatic test_freeze_restart();
    obs_t s0;
    frame(1, 0, 0);
    frame(1, 0, 1);
    s0 = last0;
    for (int n = 0; n < 100; n++) begin
      frame(1, 0, 0);
      checks++;
      if (obs_x0 !== s0.x || sc0 !== s0.sc) begin
        errors++; $display("FAIL frozen got x=%h sc=%0d want x=%h sc=%0d", obs_x0, sc0, s0.x, s0.sc);
      end
    end
    frame(0, 1, 0);
    checks++;
    if ({v0, v1, sc0} !== {3'd0, 3'd0, s0.sc}) begin
      errors++; $display("FAIL restart got v=%b/%b sc=%0d want 0/0 %0d", v0, v1, sc0, s0.sc);
    end
    frame(0, 0, 0);
  endtask

  task automatic test_speed_ramp();
    frame(1, 0, 0);
    for (int n = 1; n <= 3600; n++) begin
      frame(1, 0, 0);
      if (n == 599) begin
        checks++;
        if (sp0 !== 4'd3) begin errors++; $display("FAIL ramp599 got %0d want 3", sp0); end
      end
      if (n == 600) begin
        checks++;
        if ({sp0, lv0, sp1} !== {4'd4, 4'd1, 4'd4}) begin
          errors++; $display("FAIL ramp600 got sp=%0d lv=%0d sp1=%0d want 4 1 4", sp0, lv0, sp1);
        end
      end
      if (n == 3000 || n == 3600) begin
        checks++;
        if ({sp0, lv0} !== {4'd8, 4'd5}) begin
          errors++; $display("FAIL ramp%0d got sp=%0d lv=%0d want 8 5", n, sp0, lv0);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset(0); m_reset(1);
    last0 = '0; last1 = '0;
    test_reset();
    test_first_spawn();
    test_retire_and_exhaustion();
    test_pause();
    test_freeze_restart();
    test_speed_ramp();
    test_reset();
    test_first_spawn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate controller that owns the obstacle field for the dinosaur game. It runs up to `NUM_SLOTS` obstacles at once and spawns new ones after LFSR-randomised gaps. Obstacle speed ramps up with elapsed play time, and each obstacle that scrolls off-screen adds one to the score. It sits beside the game module on `game_clk`. It consumes the game's run/collision status, and its slot positions feed the collision check and the renderer.

## Interface
- `NUM_SLOTS`, 3: concurrent obstacle slots (1–4).
- `SPAWN_X`, 400: signed x at which a new obstacle appears.
- `DESPAWN_X`, -32: an obstacle is retired once its x is at or below this value.
- `MIN_GAP`, 40: minimum number of advancing frames between spawns.
- `GAP_MASK`, 63: mask applied to the LFSR value to form the random extra gap.
- `SPEED_INIT`, 3: initial speed in pixels per frame.
- `SPEED_MAX`, 8: speed saturation value.
- `LEVEL_FRAMES`, 600: advancing frames per speed step.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `game_clk` in 1: frame clock, about 60 Hz. This is the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: when 1, the field advances this frame; when 0, the field is paused.
- `restart` in 1: return to IDLE and clear the field.
- `collided` in 1: collision reported by the game; freezes the field.
- `obs_x` out 12·NUM_SLOTS: signed x of each slot; slot i occupies bits [12i+11:12i].
- `obs_valid` out NUM_SLOTS: slot occupied.
- `speed` out 4: current pixels per frame.
- `level` out 4: number of speed steps taken.
- `score` out 16: count of retired obstacles, saturating.
- `spawn_pulse` out 1: high for one frame when a spawn occurs.

## Operation
State machine:
- IDLE → RUN when `run`=1.
  - On entry, all slots are cleared, `gap_timer`=MIN_GAP, `frame_cnt`=0, `speed`=SPEED_INIT, `level`=0 and `score`=0.
- RUN → FROZEN when `collided`=1. That frame performs no movement, no spawn and no scoring.
- FROZEN holds every output until `restart`.
- `restart` in any state → IDLE. All slots are cleared and `score` is held at its value for display until the next IDLE→RUN.
- Priority: `rst` > `restart` > `collided` > advance.

An advancing frame is a frame in RUN with `run`=1 and `collided`=0. Nothing changes in RUN when `run`=0. On each advancing frame:
- **Move:** every valid slot computes `x ← x − speed` in 12-bit signed arithmetic.
  - If the new x ≤ DESPAWN_X, the slot's `valid` is cleared and `score` increments, saturating at 16'hFFFF.
  - Several retirements in one frame add their count.
- **Spawn:**
  - If `gap_timer`≠0, it decrements.
  - If `gap_timer`=0 and a free slot exists (judged on the registered `obs_valid`), the lowest-index free slot gets x=SPAWN_X and valid=1. `spawn_pulse` goes to 1 and `gap_timer` reloads to MIN_GAP + (lfsr & GAP_MASK).
  - If no slot is free, `gap_timer` holds at 0 and the spawn retries on the next advancing frame.
  - A slot retired this frame is not reusable until the next frame.
  - A newly spawned obstacle is not moved on its spawn frame.
- **LFSR:** steps once per advancing frame.
- **Level:**
  - `frame_cnt` counts advancing frames. When it reaches LEVEL_FRAMES−1 it wraps to 0.
  - On that wrap, if `speed` < SPEED_MAX, `speed` and `level` both increment; otherwise both hold.

## Timing
- All outputs are registered and change only on the rising edge of `game_clk`, or asynchronously on `rst`.
- Reset values:
  - state IDLE
  - `obs_valid`=0
  - every `obs_x`=0
  - `speed`=SPEED_INIT
  - `level`=0
  - `score`=0
  - `spawn_pulse`=0
  - `gap_timer`=MIN_GAP
  - `frame_cnt`=0
  - lfsr=LFSR_SEED
- Input-to-output latency is one edge.
- The first spawn occurs on advancing edge number MIN_GAP+1 after the IDLE→RUN edge.
- `rst` asserted mid-frame clears the block immediately. Operation resumes at the first edge after release, in IDLE.

## Structure
- Defaults for SPAWN_X, DESPAWN_X, speed limits and the state encodings belong in the shared `parameters.v` include, alongside the existing screen constants.
- Sub-module `lfsr16`: 16-bit Galois LFSR with taps 16,14,13,11 (mask 16'hB400), plus enable and seed parameter. It is reused elsewhere for cactus variant selection.

## Test plan
- **Reset:** assert `rst` mid-RUN → next sample shows `obs_valid`=0, `speed`=3, `score`=0, `spawn_pulse`=0, state IDLE.
- **First spawn:** `run`=1 from IDLE → `spawn_pulse` on the 41st advancing edge, with `obs_x[0]`=400 and `obs_valid[0]`=1. The next edge shows `obs_x[0]`=397.
- **Retirement:** a lone slot spawned at 400 with speed 3 → `obs_valid[0]` clears and `score`=1 on its 144th move edge (x=−32).
- **Speed ramp:** 600 advancing frames → `speed`=4, `level`=1. 3000 frames → `speed`=8. 3600 frames → still 8, `level`=5.
- **Freeze and restart:** `collided` pulse → `obs_x`/`score` constant for 100 frames even with `run`=1. `restart` → IDLE, `obs_valid`=0.
- **Slot exhaustion and pause:** MIN_GAP=1, GAP_MASK=0, NUM_SLOTS=3 → spawns every 2nd frame into slots 0,1,2. The fourth spawn waits, with `gap_timer` held at 0, until the frame after slot 0 retires, then lands in slot 0. Separately, `run`=0 for 10 frames → all outputs unchanged.
